// File: rtl/decode_stage_pkg.sv
// Shared decode types: ALU ops, stage FSM states, opcode/funct encodings
// and the decoded control word carried from decode to execute.
package decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} dec_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                           OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B,
                           OP_LL    = 6'h30, OP_SC   = 6'h38, OP_HALT = 6'h3F;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_JR   = 6'h08,
                           F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22,
                           F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
                           F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A,
                           F_SLTU = 6'h2B;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [1:0]  RegDst;
        logic        ExtOp;
        logic [1:0]  ALUSrc;
        aluop_t      ALUctr;
        logic [1:0]  MemToReg;
        logic [1:0]  PCSrc;
        logic        RegWr;
        logic        dREN;
        logic        dWEN;
        logic        datomic;
        logic        halt;
        logic        illegal;
    } decode_ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage.
interface decode_stage_if #(parameter int PC_W = 32);
    import decode_stage_pkg::*;

    logic            fetch_valid;
    logic [31:0]     fetch_instr;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_ready;
    logic            dec_valid;
    logic            dec_ready;
    logic [PC_W-1:0] dec_pc;
    decode_ctrl_t    dec_ctrl;

    modport master (output fetch_valid, fetch_instr, fetch_pc, dec_ready,
                    input  fetch_ready, dec_valid, dec_pc, dec_ctrl);
    modport slave  (input  fetch_valid, fetch_instr, fetch_pc, dec_ready,
                    output fetch_ready, dec_valid, dec_pc, dec_ctrl);
endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Pure combinational instruction word -> control word decoder; shared with
// the single-cycle datapath.
module instr_decoder
    import decode_stage_pkg::*;
#(
    parameter bit ATOMIC_EN = 1'b1
) (
    input  logic [31:0]  instr,
    output decode_ctrl_t ctrl
);
    always_comb begin
        ctrl          = '0;
        ctrl.opcode   = instr[31:26];
        ctrl.rs       = instr[25:21];
        ctrl.rt       = instr[20:16];
        ctrl.rd       = instr[15:11];
        ctrl.shamt    = instr[10:6];
        ctrl.funct    = instr[5:0];
        ctrl.imm16    = instr[15:0];
        ctrl.imm26    = instr[25:0];
        ctrl.RegDst   = 2'd1;
        ctrl.ExtOp    = 1'b1;
        ctrl.ALUctr   = ALU_ADD;
        case (instr[31:26])
            OP_RTYPE: begin
                ctrl.RegDst = 2'd0;
                // JR and the all-zero NOP never write the register file
                ctrl.RegWr  = (instr[5:0] != F_JR) && (instr != 32'h0);
                case (instr[5:0])
                    F_SLL:          ctrl.ALUctr = ALU_SLL;
                    F_SRL:          ctrl.ALUctr = ALU_SRL;
                    F_ADD, F_ADDU:  ctrl.ALUctr = ALU_ADD;
                    F_SUB, F_SUBU:  ctrl.ALUctr = ALU_SUB;
                    F_AND:          ctrl.ALUctr = ALU_AND;
                    F_OR:           ctrl.ALUctr = ALU_OR;
                    F_XOR:          ctrl.ALUctr = ALU_XOR;
                    F_NOR:          ctrl.ALUctr = ALU_NOR;
                    F_SLT:          ctrl.ALUctr = ALU_SLT;
                    F_SLTU:         ctrl.ALUctr = ALU_SLTU;
                    F_JR:           ctrl.PCSrc  = 2'd1;
                    default:        ctrl.illegal = 1'b1;
                endcase
            end
            OP_J:   ctrl.PCSrc = 2'd2;
            OP_JAL: begin
                ctrl.RegDst   = 2'd2;
                ctrl.MemToReg = 2'd2;
                ctrl.PCSrc    = 2'd2;
                ctrl.RegWr    = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.ALUctr = ALU_SUB;
                ctrl.PCSrc  = 2'd3;
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.ALUSrc = 2'd1;
                ctrl.RegWr  = 1'b1;
            end
            OP_SLTI, OP_SLTIU: begin
                ctrl.ALUSrc = 2'd1;
                ctrl.ALUctr = (instr[31:26] == OP_SLTI) ? ALU_SLT : ALU_SLTU;
                ctrl.RegWr  = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.ExtOp  = 1'b0;
                ctrl.ALUSrc = 2'd1;
                ctrl.RegWr  = 1'b1;
                ctrl.ALUctr = (instr[31:26] == OP_ANDI) ? ALU_AND :
                              (instr[31:26] == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                ctrl.ALUSrc = 2'd2;
                ctrl.RegWr  = 1'b1;
            end
            OP_LW: begin
                ctrl.ALUSrc   = 2'd1;
                ctrl.MemToReg = 2'd1;
                ctrl.RegWr    = 1'b1;
                ctrl.dREN     = 1'b1;
            end
            OP_SW: begin
                ctrl.ALUSrc = 2'd1;
                ctrl.dWEN   = 1'b1;
            end
            OP_LL, OP_SC: begin
                if (ATOMIC_EN) begin
                    ctrl.ALUSrc   = 2'd1;
                    ctrl.MemToReg = 2'd1;
                    ctrl.RegWr    = 1'b1;
                    ctrl.datomic  = 1'b1;
                    ctrl.dREN     = (instr[31:26] == OP_LL);
                    ctrl.dWEN     = (instr[31:26] == OP_SC);
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_HALT: ctrl.halt = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
        // an illegal word must not disturb architectural state or control flow
        if (ctrl.illegal) begin
            ctrl.RegWr   = 1'b0;
            ctrl.dREN    = 1'b0;
            ctrl.dWEN    = 1'b0;
            ctrl.datomic = 1'b0;
            ctrl.PCSrc   = 2'd0;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// Buffered decode stage: fetch queue, registered decoded output with
// bypass from fetch when the queue is empty, and RUN/DRAIN/HALTED sequencing.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PC_W      = 32,
    parameter bit ATOMIC_EN = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RST,
    decode_stage_if.slave              bus,
    input  logic                       flush,
    output logic                       halt,
    output logic [$clog2(DEPTH+2)-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+2);

    logic [31:0]     q_instr [DEPTH];
    logic [PC_W-1:0] q_pc    [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, count;
    dec_state_t      state;
    logic            dec_valid_q;
    logic [PC_W-1:0] dec_pc_q;
    decode_ctrl_t    dec_ctrl_q, ld_ctrl;
    logic            q_empty, q_full, accept, consume, load_en, pop, bypass, push, load_any;
    logic [31:0]     ld_instr;
    logic [PC_W-1:0] ld_pc;

    assign q_empty  = (wr_ptr == rd_ptr);
    assign q_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;

    assign bus.fetch_ready = (state == RUN) && !q_full && !flush;
    assign accept   = bus.fetch_valid && bus.fetch_ready;
    assign consume  = dec_valid_q && bus.dec_ready;
    assign load_en  = (state == RUN) && (!dec_valid_q || consume);
    assign pop      = load_en && !q_empty;
    assign bypass   = load_en && q_empty && accept;
    assign push     = accept && !bypass;
    assign load_any = pop || bypass;

    assign ld_instr = q_empty ? bus.fetch_instr : q_instr[rd_ptr[AW-1:0]];
    assign ld_pc    = q_empty ? bus.fetch_pc    : q_pc[rd_ptr[AW-1:0]];

    assign bus.dec_valid = dec_valid_q;
    assign bus.dec_pc    = dec_pc_q;
    assign bus.dec_ctrl  = dec_ctrl_q;
    assign occupancy     = OW'(count) + OW'(dec_valid_q);

    instr_decoder #(.ATOMIC_EN(ATOMIC_EN)) u_dec (
        .instr (ld_instr),
        .ctrl  (ld_ctrl)
    );

    always_ff @(posedge CLK) begin
        if (push) begin
            q_instr[wr_ptr[AW-1:0]] <= bus.fetch_instr;
            q_pc[wr_ptr[AW-1:0]]    <= bus.fetch_pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= RUN;
            dec_valid_q <= 1'b0;
            dec_pc_q    <= '0;
            dec_ctrl_q  <= '0;
            halt        <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush) begin
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        dec_valid_q <= 1'b0;
                    end else begin
                        if (push) wr_ptr <= wr_ptr + 1'b1;
                        if (pop)  rd_ptr <= rd_ptr + 1'b1;
                        if (load_en) begin
                            dec_valid_q <= load_any;
                            if (load_any) begin
                                dec_ctrl_q <= ld_ctrl;
                                dec_pc_q   <= ld_pc;
                            end
                            // younger words behind a HALT are dropped
                            if (load_any && ld_ctrl.halt) begin
                                state  <= DRAIN;
                                wr_ptr <= '0;
                                rd_ptr <= '0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        state       <= RUN;
                        dec_valid_q <= 1'b0;
                    end else if (consume) begin
                        state       <= HALTED;
                        dec_valid_q <= 1'b0;
                        halt        <= 1'b1;
                    end
                end
                HALTED: begin
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed words, expected control words
// queued at issue and checked by an output monitor.
`timescale 1ns/1ps
module tb_decode_stage;
    import decode_stage_pkg::*;
    localparam int PC_W = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [1:0]      RegDst;
        logic            ExtOp;
        logic [1:0]      ALUSrc;
        aluop_t          ALUctr;
        logic [1:0]      MemToReg;
        logic [1:0]      PCSrc;
        logic [5:0]      flags;   // {RegWr,dREN,dWEN,datomic,halt,illegal}
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST, flush, flush2;
    logic       halt, halt2;
    logic [2:0] occupancy, occupancy2;
    int         checks = 0;
    int         passed = 0;
    exp_t       sb[$];
    exp_t       mon_w, mon_got;

    decode_stage_if #(.PC_W(PC_W)) bus  ();
    decode_stage_if #(.PC_W(PC_W)) bus2 ();

    decode_stage #(.DEPTH(4), .PC_W(PC_W), .ATOMIC_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .flush(flush), .halt(halt), .occupancy(occupancy));

    decode_stage #(.DEPTH(4), .PC_W(PC_W), .ATOMIC_EN(1'b0)) dut_na (
        .CLK(CLK), .RST(RST), .bus(bus2), .flush(flush2), .halt(halt2), .occupancy(occupancy2));

    always #5 CLK = ~CLK;

    function automatic exp_t ex(input logic [PC_W-1:0] pc, input logic [1:0] rdst,
                                input logic ext, input logic [1:0] src, input aluop_t alu,
                                input logic [1:0] m2r, input logic [1:0] pcs, input logic [5:0] fl);
        exp_t e;
        e.pc = pc; e.RegDst = rdst; e.ExtOp = ext; e.ALUSrc = src; e.ALUctr = alu;
        e.MemToReg = m2r; e.PCSrc = pcs; e.flags = fl;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s got %h want %h", name, got, want);
    endtask

    always @(negedge CLK) begin
        if (!RST && bus.dec_valid && bus.dec_ready) begin
            mon_got.pc       = bus.dec_pc;
            mon_got.RegDst   = bus.dec_ctrl.RegDst;
            mon_got.ExtOp    = bus.dec_ctrl.ExtOp;
            mon_got.ALUSrc   = bus.dec_ctrl.ALUSrc;
            mon_got.ALUctr   = bus.dec_ctrl.ALUctr;
            mon_got.MemToReg = bus.dec_ctrl.MemToReg;
            mon_got.PCSrc    = bus.dec_ctrl.PCSrc;
            mon_got.flags    = {bus.dec_ctrl.RegWr, bus.dec_ctrl.dREN, bus.dec_ctrl.dWEN,
                                bus.dec_ctrl.datomic, bus.dec_ctrl.halt, bus.dec_ctrl.illegal};
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output got pc %h want no output", bus.dec_pc);
            end else begin
                mon_w = sb.pop_front();
                check($sformatf("dec_pc_%h", mon_w.pc), 64'(mon_got), 64'(mon_w));
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [PC_W-1:0] pc,
                        input bit exp_en, input exp_t e);
        int  n = 0;
        logic r;
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = instr;
        bus.fetch_pc    = pc;
        if (exp_en) sb.push_back(e);
        forever begin
            @(negedge CLK); r = bus.fetch_ready;
            @(posedge CLK);
            if (r) break;
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL send_timeout pc %h got fetch_ready=0 want 1", pc);
                break;
            end
        end
        #1 bus.fetch_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge CLK); #1; n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; flush = 1'b0; flush2 = 1'b0;
        bus.fetch_valid  = 1'b0; bus.fetch_instr  = '0; bus.fetch_pc  = '0; bus.dec_ready  = 1'b0;
        bus2.fetch_valid = 1'b0; bus2.fetch_instr = '0; bus2.fetch_pc = '0; bus2.dec_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        @(negedge CLK);
        check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_fetch_ready", 64'(bus.fetch_ready), 64'd1);
        check("rst_dec_pc", 64'(bus.dec_pc), 64'd0);
        check("rst_dec_ctrl_nonzero", 64'(bus.dec_ctrl != '0), 64'd0);

        // 1: single-word latency through bypass
        step();
        send(32'h24010005, 32'h0, 1'b1, ex(32'h0, 2'd1, 1'b1, 2'd1, ALU_ADD, 2'd0, 2'd0, 6'b100000));
        @(negedge CLK);
        check("t1_dec_valid", 64'(bus.dec_valid), 64'd1);
        step();
        bus.dec_ready = 1'b1;
        wait_empty();
        bus.dec_ready = 1'b0;

        // 2: fill queue + output register, stall, release in order
        send(32'h00221820, 32'h00, 1'b1, ex(32'h00, 2'd0, 1'b1, 2'd0, ALU_ADD, 2'd0, 2'd0, 6'b100000));
        send(32'h3C041234, 32'h04, 1'b1, ex(32'h04, 2'd1, 1'b1, 2'd2, ALU_ADD, 2'd0, 2'd0, 6'b100000));
        send(32'h34A5FFFF, 32'h08, 1'b1, ex(32'h08, 2'd1, 1'b0, 2'd1, ALU_OR,  2'd0, 2'd0, 6'b100000));
        send(32'h8C260004, 32'h0C, 1'b1, ex(32'h0C, 2'd1, 1'b1, 2'd1, ALU_ADD, 2'd1, 2'd0, 6'b110000));
        send(32'hAC270008, 32'h10, 1'b1, ex(32'h10, 2'd1, 1'b1, 2'd1, ALU_ADD, 2'd0, 2'd0, 6'b001000));
        fork
            send(32'h10220003, 32'h14, 1'b1, ex(32'h14, 2'd1, 1'b1, 2'd0, ALU_SUB, 2'd0, 2'd3, 6'b000000));
            begin
                @(negedge CLK);
                check("t2_full_fetch_ready", 64'(bus.fetch_ready), 64'd0);
                check("t2_full_occupancy", 64'(occupancy), 64'd5);
                repeat (2) @(posedge CLK);
                #1 bus.dec_ready = 1'b1;
            end
        join
        wait_empty();

        // 3: streaming with dec_ready held high
        send(32'h03E00008, 32'h20, 1'b1, ex(32'h20, 2'd0, 1'b1, 2'd0, ALU_ADD,  2'd0, 2'd1, 6'b000000));
        send(32'h00000000, 32'h24, 1'b1, ex(32'h24, 2'd0, 1'b1, 2'd0, ALU_SLL,  2'd0, 2'd0, 6'b000000));
        send(32'h0C000010, 32'h28, 1'b1, ex(32'h28, 2'd2, 1'b1, 2'd0, ALU_ADD,  2'd2, 2'd2, 6'b100000));
        send(32'h7C000000, 32'h2C, 1'b1, ex(32'h2C, 2'd1, 1'b1, 2'd0, ALU_ADD,  2'd0, 2'd0, 6'b000001));
        send(32'hC0220000, 32'h30, 1'b1, ex(32'h30, 2'd1, 1'b1, 2'd1, ALU_ADD,  2'd1, 2'd0, 6'b110100));
        send(32'hE0220000, 32'h34, 1'b1, ex(32'h34, 2'd1, 1'b1, 2'd1, ALU_ADD,  2'd1, 2'd0, 6'b101100));
        send(32'h38A5000F, 32'h38, 1'b1, ex(32'h38, 2'd1, 1'b0, 2'd1, ALU_XOR,  2'd0, 2'd0, 6'b100000));
        send(32'h2C22FFFF, 32'h3C, 1'b1, ex(32'h3C, 2'd1, 1'b1, 2'd1, ALU_SLTU, 2'd0, 2'd0, 6'b100000));
        wait_empty();
        bus.dec_ready = 1'b0;

        // 4: HALT behind a stalled word; younger words dropped, sticky halt
        send(32'h24010005, 32'h40, 1'b1, ex(32'h40, 2'd1, 1'b1, 2'd1, ALU_ADD, 2'd0, 2'd0, 6'b100000));
        send(32'hFFFFFFFF, 32'h44, 1'b1, ex(32'h44, 2'd1, 1'b1, 2'd0, ALU_ADD, 2'd0, 2'd0, 6'b000010));
        send(32'h24020001, 32'h48, 1'b0, '0);
        send(32'h24030002, 32'h4C, 1'b0, '0);
        @(negedge CLK);
        check("t4_occupancy", 64'(occupancy), 64'd4);
        step();
        bus.dec_ready = 1'b1;
        wait_empty();
        @(negedge CLK);
        check("t4_halt", 64'(halt), 64'd1);
        check("t4_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("t4_fetch_ready", 64'(bus.fetch_ready), 64'd0);
        check("t4_occupancy_halted", 64'(occupancy), 64'd0);
        step();
        flush = 1'b1; bus.fetch_valid = 1'b1; bus.fetch_instr = 32'h24010005;
        step();
        flush = 1'b0;
        step();
        bus.fetch_valid = 1'b0;
        @(negedge CLK);
        check("t4_halt_sticky", 64'(halt), 64'd1);
        check("t4_halted_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("t4_halted_occupancy", 64'(occupancy), 64'd0);
        bus.dec_ready = 1'b0;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        @(negedge CLK);
        check("t4_rst_halt", 64'(halt), 64'd0);
        check("t4_rst_fetch_ready", 64'(bus.fetch_ready), 64'd1);
        check("t4_rst_occupancy", 64'(occupancy), 64'd0);

        // 5: flush with a full stage, then flush out of DRAIN
        step();
        for (int i = 0; i < 5; i++) send(32'h24010005, 32'(32'h50 + 4 * i), 1'b0, '0);
        @(negedge CLK);
        check("t5_full_occupancy", 64'(occupancy), 64'd5);
        step();
        flush = 1'b1;
        @(negedge CLK);
        check("t5_flush_fetch_ready", 64'(bus.fetch_ready), 64'd0);
        step();
        flush = 1'b0;
        @(negedge CLK);
        check("t5_flush_occupancy", 64'(occupancy), 64'd0);
        check("t5_flush_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("t5_flush_fetch_ready_after", 64'(bus.fetch_ready), 64'd1);
        step();
        send(32'hFFFFFFFF, 32'h70, 1'b0, '0);
        @(negedge CLK);
        check("t5_drain_fetch_ready", 64'(bus.fetch_ready), 64'd0);
        check("t5_drain_dec_valid", 64'(bus.dec_valid), 64'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge CLK);
        check("t5_dflush_occupancy", 64'(occupancy), 64'd0);
        check("t5_dflush_halt", 64'(halt), 64'd0);
        check("t5_dflush_fetch_ready", 64'(bus.fetch_ready), 64'd1);
        check("t5_dflush_dec_valid", 64'(bus.dec_valid), 64'd0);
        step();
        bus.dec_ready = 1'b1;
        send(32'h24010005, 32'h80, 1'b1, ex(32'h80, 2'd1, 1'b1, 2'd1, ALU_ADD, 2'd0, 2'd0, 6'b100000));
        wait_empty();
        bus.dec_ready = 1'b0;

        // 6: LL with atomics disabled is illegal with no side effects
        bus2.fetch_valid = 1'b1; bus2.fetch_instr = 32'hC0220000; bus2.fetch_pc = '0;
        step();
        bus2.fetch_valid = 1'b0;
        @(negedge CLK);
        check("t6_na_dec_valid", 64'(bus2.dec_valid), 64'd1);
        check("t6_na_illegal", 64'(bus2.dec_ctrl.illegal), 64'd1);
        check("t6_na_dREN", 64'(bus2.dec_ctrl.dREN), 64'd0);
        check("t6_na_datomic", 64'(bus2.dec_ctrl.datomic), 64'd0);
        check("t6_na_RegWr", 64'(bus2.dec_ctrl.RegWr), 64'd0);

        repeat (5) @(posedge CLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
